// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the CPU MEM stage and a DMA/loader requester.
// Optional macro DMEM_TIMEOUT_EN aborts a BUSY access that sees no mem_ack for TIMEOUT_CYCLES.
module dmem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int MAX_CPU_STREAK = 4,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int STREAK_W      = $clog2(MAX_CPU_STREAK + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [31:0]         cpu_wdata,
  input  logic [3:0]          cpu_we,
  output logic [31:0]         cpu_rdata,
  output logic                cpu_done,
  output logic                cpu_err,
  output logic                cpu_stall,
  input  logic                dma_req,
  input  logic [ADDR_W-1:0]   dma_addr,
  input  logic [31:0]         dma_wdata,
  input  logic [3:0]          dma_we,
  output logic [31:0]         dma_rdata,
  output logic                dma_done,
  output logic                dma_err,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  output logic [3:0]          mem_we,
  input  logic                mem_ack,
  input  logic [31:0]         mem_rdata,
  output logic [1:0]          state_dbg,
  output logic [STREAK_W-1:0] streak_dbg
);

  // Handshake: a requester holds req and its fields stable until its done pulse and
  // drops req at the edge ending that cycle; mem_req/fields stay constant until mem_ack.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_CPU = 2'd1,
    BUSY_DMA = 2'd2
  } state_t;

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic                busy;
  logic                timeout_hit;
  logic                finish;
  logic                streak_max;
  logic                dma_win;
  logic [31:0]         load_data;

  assign busy       = (state != IDLE);
  assign streak_max = (streak == STREAK_W'(MAX_CPU_STREAK));
  // DMA takes the port when the CPU is absent or has used up its streak.
  assign dma_win    = dma_req && (!cpu_req || streak_max);

`ifdef DMEM_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TIMER_W-1:0] timer;

  // mem_ack on the limit cycle wins, so the abort needs mem_ack low.
  assign timeout_hit = busy && !mem_ack && (timer == TIMER_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (!busy) begin
      timer <= '0;
    end else if (!mem_ack) begin
      timer <= timer + TIMER_W'(1);
    end
  end

  assign cpu_err = cpu_done && timeout_hit;
  assign dma_err = dma_done && timeout_hit;
`else
  assign timeout_hit = 1'b0;
  assign cpu_err     = 1'b0;
  assign dma_err     = 1'b0;
`endif

  assign finish    = busy && (mem_ack || timeout_hit);
  assign load_data = (timeout_hit || (mem_we != 4'h0)) ? 32'h0 : mem_rdata;

  assign cpu_done  = finish && (state == BUSY_CPU);
  assign dma_done  = finish && (state == BUSY_DMA);
  assign cpu_rdata = cpu_done ? load_data : 32'h0;
  assign dma_rdata = dma_done ? load_data : 32'h0;
  assign cpu_stall = cpu_req && !cpu_done;

  assign state_dbg  = state;
  assign streak_dbg = streak;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      mem_we    <= 4'h0;
      streak    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dma_win) begin
            state     <= BUSY_DMA;
            mem_req   <= 1'b1;
            mem_addr  <= dma_addr;
            mem_wdata <= dma_wdata;
            mem_we    <= dma_we;
            streak    <= '0;
          end else if (cpu_req) begin
            state     <= BUSY_CPU;
            mem_req   <= 1'b1;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            mem_we    <= cpu_we;
            if (!dma_req) begin
              streak <= '0;
            end else if (!streak_max) begin
              streak <= streak + STREAK_W'(1);
            end
          end else begin
            streak <= '0;
          end
        end
        default: begin
          // Address and write data stay on the bus after completion.
          if (finish) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 4'h0;
          end
        end
      endcase
    end
  end

endmodule
